fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch front end of the core. Owns the PC and drives the word address into IMEM.
//  Captures IMEM's same-cycle (asynchronous-read) instruction into an IF/ID register.
//  Hands the registered instruction to decode over a valid/ready handshake.
//  Handles redirects (branch/jump/trap) and fault-stops on bad fetch addresses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  IMEM_WORDS 1024           IMEM depth in words; legal fetch range is 0 .. IMEM_WORDS*4-1
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  fetch_en       in   1   1 = fetching allowed
//  imem_addr      out  32  byte address to IMEM; combinational = pc_q
//  imem_instr     in   32  IMEM read data for imem_addr, valid in the same cycle
//  redirect_valid in   1   load redirect_pc and flush IF/ID this cycle
//  redirect_pc    in   32  redirect target (byte address)
//  id_valid       out  1   IF/ID holds a valid instruction
//  id_ready       in   1   decode accepts IF/ID this cycle
//  id_pc          out  32  PC of id_instr
//  id_instr       out  32  fetched instruction
//  fault_valid    out  1   fetch unit is in FAULT
//  fault_cause    out  2   2'b01 misaligned PC, 2'b10 PC out of range, 2'b00 none
//  fetch_count    out  32  number of instructions accepted by decode
// BEHAVIOUR
//  Reset values:
//   - pc_q=RESET_PC, state=IDLE, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP).
//   - fault_valid=0, fault_cause=0, fetch_count=0.
//  Definitions:
//   - slot_free = !id_valid || id_ready.
//   - bad_pc = (pc_q[1:0]!=0) || (pc_q >= IMEM_WORDS*4). Misaligned takes precedence in fault_cause.
//  States:
//   - IDLE: no fetch. Go to RUN when fetch_en=1.
//   - RUN: when slot_free and !bad_pc, load IF/ID: id_valid<=1, id_pc<=pc_q, id_instr<=imem_instr.
//     In the same cycle, pc_q<=pc_q+4 (mod 2^32, wraps silently). Fetch latency is 1 cycle.
//   - RUN, bad_pc: no fetch. id_valid<=0 once the slot is free. Go to FAULT; set fault_cause.
//   - RUN, fetch_en=0: no new fetch. The held IF/ID entry stays until consumed. Go to IDLE.
//   - FAULT: no fetch; fault_valid=1; fault_cause is held. Leave only by redirect.
//  Handshake:
//   - While id_valid=1 and id_ready=0, id_pc and id_instr are stable and pc_q holds.
//   - Back-to-back fetch (one instruction per cycle) when id_ready stays high.
//  Redirect (priority over everything, any state):
//   - pc_q<=redirect_pc; id_valid<=0 (IF/ID flushed); no fetch this cycle.
//   - Next state: FAULT or IDLE or RUN as re-evaluated from the new pc_q next cycle.
//   - From FAULT, the next state is RUN if fetch_en=1, else IDLE. fault_valid and fault_cause clear.
//   - A misaligned or out-of-range redirect_pc is accepted into pc_q; the fault is raised next cycle via bad_pc.
//  fetch_count:
//   - Increments on id_valid && id_ready && !redirect_valid. Wraps 2^32-1 -> 0.
//   - An instruction killed by a simultaneous redirect is not counted; decode must also discard it.
//  rst_n low mid-operation: all state returns to reset values immediately (async). The held instruction is lost.
//  First fetch after reset release: cycle N+1 if fetch_en=1 at cycle N.
// STRUCTURE
//  fetch_pkg:
//   - NOP_INSTR = 32'h0000_0013.
//   - fetch_state_t {IDLE, RUN, FAULT}.
//   - fault_cause_t {FC_NONE, FC_MISALIGN, FC_RANGE}.
//  Sub-module if_id_reg: valid/ready skid-less pipeline register holding {pc, instr}, with a flush input.
//  The PC, FSM and counter live in fetch_unit; no other sub-modules.
// TESTING
//  1. Reset, fetch_en=1, id_ready=1, IMEM of NOPs:
//     -> id_pc 0,4,8,... on consecutive cycles; fetch_count=N after N accepts.
//  2. id_ready=0 for 3 cycles at id_pc=8:
//     -> id_pc/id_instr held at 8; imem_addr stays 12; resumes 12,16 when id_ready=1.
//  3. redirect_valid with redirect_pc=0x100 while id_valid=1 and id_ready=1:
//     -> id_valid=0 next cycle; next id_pc=0x100; fetch_count not incremented for the killed instruction.
//  4. redirect_pc=0x102:
//     -> FAULT with fault_cause=01; id_valid stays 0; redirect to 0x40 -> RUN, fault_valid=0, id_pc=0x40.
//  5. Run sequentially to pc=0xFFC:
//     -> fetch at 0xFFC; pc=0x1000 -> FAULT with fault_cause=10.
//  6. Assert rst_n low while id_ready=0 holds an instruction:
//     -> all outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_MISALIGN = 2'b01,
      FC_RANGE    = 2'b10
   } fault_cause_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_t;

   // Classify a fetch address; misalignment wins over range.
   function automatic fault_cause_t pc_fault(input logic [XLEN-1:0] pc,
                                             input logic [XLEN-1:0] limit);
      if (pc[1:0] != 2'b00) return FC_MISALIGN;
      if (pc >= limit)      return FC_RANGE;
      return FC_NONE;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one {pc, instr} entry with valid/ready and flush.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            load,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   input  logic            ready,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr
);

   if_id_t entry_q;

   // Flush beats load; an unreloaded entry retires when decode takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid   <= 1'b0;
         entry_q <= '{pc: '0, instr: NOP_INSTR};
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid   <= 1'b1;
         entry_q <= '{pc: pc_in, instr: instr_in};
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

   assign pc    = entry_q.pc;
   assign instr = entry_q.instr;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, drives IMEM, fills IF/ID, handles redirects and fetch faults.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        fault_valid,
   output logic [1:0]  fault_cause,
   output logic [31:0] fetch_count
);

   localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * 4);

   fetch_state_t    state_q, state_d;
   fault_cause_t    cause_q, cause_d;
   fault_cause_t    pc_cause;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] fetch_count_q;
   logic            slot_free;
   logic            bad_pc;
   logic            fetch;

   assign pc_cause  = pc_fault(pc_q, PC_LIMIT);
   assign bad_pc    = (pc_cause != FC_NONE);
   assign slot_free = !id_valid || id_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Redirect re-enters IDLE/RUN; a bad target is caught from RUN next cycle.
   always_comb begin
      state_d = state_q;
      if (redirect_valid) begin
         state_d = fetch_en ? RUN : IDLE;
      end else begin
         case (state_q)
            IDLE:    if (fetch_en) state_d = RUN;
            RUN: begin
               if (!fetch_en)   state_d = IDLE;
               else if (bad_pc) state_d = FAULT;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      fetch   = 1'b0;
      cause_d = cause_q;
      if (redirect_valid) begin
         cause_d = FC_NONE;
      end else if (state_q == RUN && fetch_en) begin
         if (bad_pc) cause_d = pc_cause;
         else        fetch   = slot_free;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         cause_q       <= FC_NONE;
         fetch_count_q <= '0;
      end else begin
         cause_q <= cause_d;
         if (redirect_valid)  pc_q <= redirect_pc;
         else if (fetch)      pc_q <= pc_q + XLEN'(4);
         if (id_valid && id_ready && !redirect_valid)
            fetch_count_q <= fetch_count_q + XLEN'(1);
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .load     (fetch),
      .pc_in    (pc_q),
      .instr_in (imem_instr),
      .ready    (id_ready),
      .valid    (id_valid),
      .pc       (id_pc),
      .instr    (id_instr)
   );

   assign imem_addr   = pc_q;
   assign fault_valid = (state_q == FAULT);
   assign fault_cause = cause_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: planned PC streams are queued, a monitor checks every accept.
module tb_fetch_unit;

   localparam int unsigned WORDS = 1024;
   localparam logic [31:0] LIMIT = 32'(WORDS * 4);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        fault_valid;
   logic [1:0]  fault_cause;
   logic [31:0] fetch_count;

   logic [31:0] mem [WORDS];
   logic [31:0] exp_pc_q[$];
   logic [31:0] exp_instr_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          acc_count = 0;

   always #5 clk = ~clk;

   assign imem_instr = (imem_addr < LIMIT) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

   fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(WORDS)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .fault_valid    (fault_valid),
      .fault_cause    (fault_cause),
      .fetch_count    (fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Expected fault for a fetch address, from the address rules alone.
   function automatic logic [31:0] exp_cause(input logic [31:0] a);
      if (a % 4 != 0) return 32'd1;
      if (a >= LIMIT) return 32'd2;
      return 32'd0;
   endfunction

   // Monitor: every accepted, unkilled instruction must be the next planned one.
   always @(negedge clk) begin
      if (!rst_n) begin
         acc_count = 0;
      end else if (id_valid && id_ready && !redirect_valid) begin
         if (exp_pc_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_accept: got pc %h expected none", id_pc);
         end else begin
            check("id_pc", id_pc, exp_pc_q.pop_front());
            check("id_instr", id_instr, exp_instr_q.pop_front());
         end
         acc_count++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic plan(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = start + 32'(4 * i);
         exp_pc_q.push_back(a);
         exp_instr_q.push_back(mem[a[11:2]]);
      end
   endtask

   task automatic redirect(input logic [31:0] target, input int n);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      id_ready       = 1'($urandom_range(0, 1));
      fetch_en       = 1'b1;
      exp_pc_q.delete();
      exp_instr_q.delete();
      plan(target, n);
      tick();
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      check("flush_id_valid", 32'(id_valid), 32'd0);
   endtask

   // Consume planned entries until only 'keep' remain; returns cycles spent.
   task automatic drain(input bit rnd_ready, input bit rnd_en, input int keep, output int cycles);
      cycles = 0;
      while (exp_pc_q.size() > keep && cycles < 400) begin
         id_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         fetch_en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
         tick();
         cycles++;
      end
      id_ready = 1'b0;
      fetch_en = 1'b1;
      if (exp_pc_q.size() > keep) begin
         n_checks++;
         $display("FAIL drain_timeout: got %0d pending expected %0d", exp_pc_q.size(), keep);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_id_valid",    32'(id_valid),    32'd0);
      check("rst_id_pc",       id_pc,            32'd0);
      check("rst_id_instr",    id_instr,         NOP);
      check("rst_fault_valid", 32'(fault_valid), 32'd0);
      check("rst_fault_cause", 32'(fault_cause), 32'd0);
      check("rst_fetch_count", fetch_count,      32'd0);
      check("rst_imem_addr",   imem_addr,        32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
      rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();
      check_reset_outputs();

      // Sequential fetch from reset, first fetch one cycle after fetch_en seen.
      rst_n = 1'b1; fetch_en = 1'b1;
      tick();
      check("first_fetch_early", 32'(id_valid), 32'd0);
      tick();
      check("first_fetch_valid", 32'(id_valid), 32'd1);
      plan(32'h0, 2);
      drain(1'b0, 1'b0, 0, cyc);
      check("b2b_cycles_0", 32'(cyc), 32'd2);

      // Stall with the entry at 8.
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", 32'(id_valid), 32'd1);
         check("stall_pc",    id_pc,         32'h8);
         check("stall_instr", id_instr,      mem[2]);
         check("stall_addr",  imem_addr,     32'hC);
      end
      plan(32'h8, 3);
      drain(1'b0, 1'b0, 0, cyc);
      check("b2b_cycles_1", 32'(cyc), 32'd3);
      check("count_seq", fetch_count, 32'(acc_count));

      // Redirect kills the valid entry at 0x14 while decode is ready.
      redirect_valid = 1'b1; redirect_pc = 32'h100; id_ready = 1'b1;
      exp_pc_q.delete(); exp_instr_q.delete();
      plan(32'h100, 4);
      tick();
      redirect_valid = 1'b0; id_ready = 1'b0;
      check("kill_id_valid", 32'(id_valid), 32'd0);
      check("kill_count", fetch_count, 32'd5);
      drain(1'b0, 1'b0, 0, cyc);
      check("b2b_cycles_2", 32'(cyc), 32'd5);

      // Misaligned redirect faults, then recover to 0x40.
      redirect(32'h102, 0);
      tick();
      check("mis_fault_valid", 32'(fault_valid), 32'd1);
      check("mis_fault_cause", 32'(fault_cause), 32'd1);
      check("mis_id_valid",    32'(id_valid),    32'd0);
      redirect(32'h40, 3);
      check("rec_fault_valid", 32'(fault_valid), 32'd0);
      check("rec_fault_cause", 32'(fault_cause), 32'd0);
      drain(1'b1, 1'b0, 0, cyc);

      // Run off the end of IMEM.
      redirect(32'hFF0, 4);
      drain(1'b1, 1'b0, 0, cyc);
      tick();
      check("end_fault_valid", 32'(fault_valid), 32'd1);
      check("end_fault_cause", 32'(fault_cause), 32'd2);
      check("end_id_valid",    32'(id_valid),    32'd0);
      check("end_imem_addr",   imem_addr,        LIMIT);
      check("count_end", fetch_count, 32'(acc_count));

      // Random segments: partial drains, pauses, random bad targets.
      for (int s = 0; s < 40; s++) begin
         if ($urandom_range(0, 5) == 0) begin
            logic [31:0] t;
            t = $urandom;
            if (t < LIMIT && t[1:0] == 2'b00) t = t | 32'h1;
            redirect(t, 0);
            tick();
            check("rnd_fault_valid", 32'(fault_valid), 32'd1);
            check("rnd_fault_cause", 32'(fault_cause), exp_cause(t));
         end else begin
            int n, idx;
            n   = $urandom_range(1, 12);
            idx = $urandom_range(0, int'(WORDS) - n);
            redirect(32'(idx * 4), n);
            drain(1'b1, 1'b1, $urandom_range(0, 2) == 0 ? $urandom_range(0, n - 1) : 0, cyc);
            tick();
            check("rnd_count", fetch_count, 32'(acc_count));
         end
      end

      // Async reset while an instruction is held.
      redirect(32'h200, 2);
      drain(1'b1, 1'b0, 0, cyc);
      tick();
      check("pre_rst_held", 32'(id_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      exp_pc_q.delete(); exp_instr_q.delete();
      tick();
      rst_n = 1'b1; fetch_en = 1'b1;
      tick(); tick();
      plan(32'h0, 3);
      drain(1'b1, 1'b0, 0, cyc);
      tick();
      check("post_rst_count", fetch_count, 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
